led_pulser: RTL

Output-side counterpart of the button input path. It converts single-cycle event pulses, such as the one-shot from a debounced button, into human-visible LED flashes of fixed width. Each flash is followed by a guaranteed dark gap. Events that arrive while a flash is in progress are queued up to a bounded count, so bursts produce distinct, countable flashes. It sits between control logic and an LED pin.

---
 rtl/led_pulser_if.sv | 9 +
 rtl/led_pulser.sv | 104 ++++++++++
 2 files changed

// File: rtl/led_pulser_if.sv
// rtl/led_pulser_if.sv - event-in / LED-out signal bundle for led_pulser
interface led_pulser_if;
  logic in;
  logic out;
  logic busy;

  modport master (output in, input out, input busy);
  modport slave  (input in, output out, output busy);
endinterface

// File: rtl/led_pulser.sv
// rtl/led_pulser.sv - stretches single-cycle events into fixed-width LED flashes
// with a guaranteed dark gap and a small saturating queue of pending events.
module led_pulser #(
  parameter int ON_CYCLES   = 12_000_000,
  parameter int OFF_CYCLES  = 6_000_000,
  parameter int MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       rst,
  led_pulser_if.slave pif
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W:0]   PEND_MAX = (PEND_W + 1)'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PEND_W-1:0]   pending;
  logic                out_q;

  logic                phase_done;
  logic                can_start;
  logic                start_queued;
  logic                start_direct;
  logic                inc;
  logic                dec;
  logic [PEND_W:0]     pend_sum;
  logic [PEND_W-1:0]   pend_next;

  // A flash may begin from IDLE or at the last GAP cycle; queued events win
  // over the live input, which is then queued instead of consumed.
  always_comb begin
    phase_done   = (cnt == '0);
    can_start    = (state == IDLE) || ((state == GAP) && phase_done);
    start_queued = can_start && (pending != '0);
    start_direct = can_start && (pending == '0) && pif.in;
    inc          = pif.in && !start_direct;
    dec          = start_queued;
    pend_sum     = {1'b0, pending} + (PEND_W + 1)'(inc) - (PEND_W + 1)'(dec);
    pend_next    = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      out_q   <= 1'b0;
    end else begin
      pending <= pend_next;
      case (state)
        IDLE: begin
          if (start_queued || start_direct) begin
            state <= ON;
            cnt   <= ON_LOAD;
            out_q <= 1'b1;
          end
        end
        ON: begin
          if (phase_done) begin
            state <= GAP;
            cnt   <= OFF_LOAD;
            out_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (phase_done) begin
            if (start_queued || start_direct) begin
              state <= ON;
              cnt   <= ON_LOAD;
              out_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          out_q <= 1'b0;
        end
      endcase
    end
  end

  assign pif.out  = out_q;
  assign pif.busy = (state != IDLE) || (pending != '0);

endmodule
